// File: rtl/fifo_async_read_stage.sv
// Read-side output stage of the async FIFO: turns empty/read plus a registered memory read
// into a valid/ready stream through a 2-entry skid buffer. Optional flush: FIFO_RD_STAGE_FLUSH_EN.
module fifo_async_read_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             nrst_in,
`ifdef FIFO_RD_STAGE_FLUSH_EN
    input  logic             flush_in,
`endif
    input  logic             empty_in,
    output logic             read_out,
    input  logic [WIDTH-1:0] rdata_in,
    output logic [WIDTH-1:0] m_data_out,
    output logic             m_valid_out,
    input  logic             m_ready_in,
    output logic [1:0]       level_out
);

    logic [1:0]       count_q, count_d;
    logic             inflight_q;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             pop;
    logic             flush;
    logic [1:0]       kept;
    logic [2:0]       occ;

`ifdef FIFO_RD_STAGE_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    assign pop  = (count_q != 2'd0) && m_ready_in;
    assign kept = count_q - {1'b0, pop};
    // Occupancy after this edge, counting the word arriving from memory now.
    assign occ  = {1'b0, kept} + {2'b00, inflight_q};

    assign read_out    = !empty_in && !flush && (occ < 3'd2);
    assign m_valid_out = (count_q != 2'd0);
    assign m_data_out  = entry0_q;
    assign level_out   = count_q;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = occ[1:0];
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                entry0_d = entry1_q;
            end
            if (inflight_q) begin
                if (kept == 2'd0) begin
                    entry0_d = rdata_in;
                end else begin
                    entry1_d = rdata_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            entry0_q   <= '0;
            entry1_q   <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= read_out;
            entry0_q   <= entry0_d;
            entry1_q   <= entry1_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!nrst_in) occ <= 3'd2);

endmodule

// File: tb/tb_fifo_async_read_stage.sv
// Randomised self-checking bench for fifo_async_read_stage against a queue-based stream model.
module tb_fifo_async_read_stage;
    localparam int unsigned W = 8;

    logic         clk_in = 1'b0;
    logic         nrst_in;
    logic         empty_in;
    logic         read_out;
    logic [W-1:0] rdata_in;
    logic [W-1:0] m_data_out;
    logic         m_valid_out;
    logic         m_ready_in;
    logic [1:0]   level_out;
    logic         flush_r;

    int total;
    int bad;

    // Source FIFO contents, words made visible so far, and the stage's expected contents.
    logic [7:0] src[$];
    int         srcpos;
    int         avail;
    logic [7:0] held[$];
    bit         infl;
    logic [7:0] pend;
    int         dut_reads;
    int         dut_deliv;

    always #5 clk_in = ~clk_in;

    fifo_async_read_stage #(.WIDTH(W)) dut (
        .clk_in     (clk_in),
        .nrst_in    (nrst_in),
`ifdef FIFO_RD_STAGE_FLUSH_EN
        .flush_in   (flush_r),
`endif
        .empty_in   (empty_in),
        .read_out   (read_out),
        .rdata_in   (rdata_in),
        .m_data_out (m_data_out),
        .m_valid_out(m_valid_out),
        .m_ready_in (m_ready_in),
        .level_out  (level_out)
    );

    task automatic model_reset();
        src.delete();
        srcpos = 0;
        avail  = 0;
        held.delete();
        infl   = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            src.push_back(rnd ? 8'($urandom) : 8'(base + 8'(i)));
        end
        avail = src.size();
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model at the rise.
    task automatic run_cycle(input bit rdy, input bit fl);
        bit e_pop, e_read, e_valid;
        int occ;
        m_ready_in = rdy;
        flush_r    = fl;
        empty_in   = (srcpos >= avail);
        rdata_in   = infl ? pend : 8'($urandom);
        @(negedge clk_in);
        e_valid = (held.size() != 0);
        e_pop   = e_valid && rdy;
        occ     = held.size() + int'(infl) - int'(e_pop);
        e_read  = !empty_in && !fl && (occ < 2);
        total++;
        if (read_out !== e_read) begin
            bad++;
            $display("FAIL read_out t=%0t got=%b want=%b", $time, read_out, e_read);
        end
        total++;
        if (m_valid_out !== e_valid) begin
            bad++;
            $display("FAIL m_valid_out t=%0t got=%b want=%b", $time, m_valid_out, e_valid);
        end
        total++;
        if (level_out !== 2'(held.size())) begin
            bad++;
            $display("FAIL level_out t=%0t got=%0d want=%0d", $time, level_out, held.size());
        end
        if (e_valid) begin
            total++;
            if (m_data_out !== held[0]) begin
                bad++;
                $display("FAIL m_data_out t=%0t got=%h want=%h", $time, m_data_out, held[0]);
            end
        end
        if (read_out === 1'b1) dut_reads++;
        if (m_valid_out === 1'b1 && rdy) dut_deliv++;
        @(posedge clk_in);
        if (fl) begin
            held.delete();
            infl = 1'b0;
        end else begin
            if (e_pop) void'(held.pop_front());
            if (infl) held.push_back(pend);
            infl = e_read;
            if (e_read) begin
                pend = src[srcpos];
                srcpos++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        nrst_in = 1'b0; empty_in = 1'b1; m_ready_in = 1'b0; flush_r = 1'b0; rdata_in = '0;
        #3;
        total++;
        if ({read_out, m_valid_out, level_out, m_data_out} !== '0) begin
            bad++;
            $display("FAIL reset_values got rd=%b v=%b lvl=%0d d=%h want all 0",
                     read_out, m_valid_out, level_out, m_data_out);
        end
        @(posedge clk_in); #1;
        nrst_in = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) run_cycle(1'($urandom), 1'b0);
    endtask

    task automatic test_fill_stream();
        int d0 = dut_deliv;
        int r0 = dut_reads;
        push_words(4, 8'hA1, 1'b0);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0);
        total++;
        if (dut_reads - r0 != 4) begin
            bad++;
            $display("FAIL fill_reads got=%0d want=4", dut_reads - r0);
        end
        total++;
        if (dut_deliv - d0 != 4) begin
            bad++;
            $display("FAIL fill_delivered got=%0d want=4", dut_deliv - d0);
        end
    endtask

    task automatic test_backpressure();
        int r0 = dut_reads;
        int d0;
        push_words(4, 8'hA1, 1'b0);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0);
        total++;
        if (dut_reads - r0 != 2) begin
            bad++;
            $display("FAIL bp_reads got=%0d want=2", dut_reads - r0);
        end
        total++;
        if (level_out !== 2'd2 || m_data_out !== 8'hA1) begin
            bad++;
            $display("FAIL bp_hold got lvl=%0d d=%h want lvl=2 d=a1", level_out, m_data_out);
        end
        d0 = dut_deliv;
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0);
        total++;
        if (dut_deliv - d0 != 4) begin
            bad++;
            $display("FAIL bp_drain got=%0d want=4", dut_deliv - d0);
        end
    endtask

    task automatic test_toggle();
        int d0 = dut_deliv;
        push_words(16, 8'h00, 1'b0);
        for (int i = 0; i < 48; i++) run_cycle(1'(i % 2 == 0), 1'b0);
        total++;
        if (dut_deliv - d0 != 16) begin
            bad++;
            $display("FAIL toggle_delivered got=%0d want=16", dut_deliv - d0);
        end
    endtask

    task automatic test_random();
        int d0 = dut_deliv;
        int n0 = src.size();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(2) == 0) push_words(1, 8'h00, 1'b1);
            run_cycle(1'($urandom), 1'b0);
        end
        for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0);
        total++;
        if (dut_deliv - d0 != src.size() - n0) begin
            bad++;
            $display("FAIL random_delivered got=%0d want=%0d", dut_deliv - d0, src.size() - n0);
        end
    endtask

    // Phase 0 resets while streaming (read in flight), phase 1 while the buffer is full.
    task automatic test_reset_midop();
        for (int p = 0; p < 2; p++) begin
            push_words(6, 8'h50, 1'b0);
            for (int i = 0; i < 5; i++) run_cycle(p == 0, 1'b0);
            if (p == 1) begin
                total++;
                if (level_out !== 2'd2) begin
                    bad++;
                    $display("FAIL midop_pre_level got=%0d want=2", level_out);
                end
            end
            #2;
            empty_in = 1'b1;
            nrst_in  = 1'b0;
            #1;
            total++;
            if ({read_out, m_valid_out, level_out, m_data_out} !== '0) begin
                bad++;
                $display("FAIL midop_async_reset p=%0d got rd=%b v=%b lvl=%0d d=%h want all 0",
                         p, read_out, m_valid_out, level_out, m_data_out);
            end
            @(posedge clk_in); #1;
            nrst_in = 1'b1;
            model_reset();
            for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0);
        end
    endtask

`ifdef FIFO_RD_STAGE_FLUSH_EN
    task automatic test_flush();
        int d0;
        push_words(6, 8'hC0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
        total++;
        if (level_out !== 2'd2) begin
            bad++;
            $display("FAIL flush_refill got=%0d want=2", level_out);
        end
        run_cycle(1'b0, 1'b1);
        d0 = dut_deliv;
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0);
        total++;
        if (dut_deliv - d0 == 0) begin
            bad++;
            $display("FAIL flush_after got=%0d want>0", dut_deliv - d0);
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0; dut_reads = 0; dut_deliv = 0; pend = '0;
        model_reset();
        test_reset();
        test_fill_stream();
        test_backpressure();
        test_toggle();
        test_random();
        test_reset_midop();
`ifdef FIFO_RD_STAGE_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
